// File: rtl/branch_resolve_stage.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_stage
// Brief   : Registered branch decision with valid/ready output and 1-entry skid.
// Revision: 1.0 - initial release
// ============================================================================
module branch_resolve_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             lt,
    input  logic             eq,
    input  logic             gt,
    input  logic [2:0]       br_op,
    input  logic [31:0]      pc,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [31:0]      out_target,
    output logic [31:0]      out_next_pc,
    output logic             flag_err,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [2:0] c_op_none = 3'b000;
    localparam logic [2:0] c_op_beq  = 3'b001;
    localparam logic [2:0] c_op_bne  = 3'b010;
    localparam logic [2:0] c_op_blt  = 3'b011;
    localparam logic [2:0] c_op_bge  = 3'b100;
    localparam logic [2:0] c_op_bgt  = 3'b101;
    localparam logic [2:0] c_op_ble  = 3'b110;
    localparam logic [2:0] c_op_jump = 3'b111;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic             w_taken_raw;
    logic             w_onehot;
    logic             w_flag_bad;
    logic             w_taken;
    logic [31:0]      w_seq_pc;
    logic [31:0]      w_target;
    logic [31:0]      w_next_pc;
    logic             w_accept;
    logic             w_xfer;
    logic             w_out_free;

    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_out_taken;
    logic             r_out_counted;
    logic [31:0]      r_out_target;
    logic [31:0]      r_out_next_pc;
    logic             r_skid_valid;
    logic             r_skid_taken;
    logic             r_skid_counted;
    logic [31:0]      r_skid_target;
    logic [31:0]      r_skid_next_pc;
    logic             r_flag_err;
    logic [CNT_W-1:0] r_branch_count;
    logic [CNT_W-1:0] r_taken_count;

    always_comb begin
        w_taken_raw = 1'b0;
        case (br_op)
            c_op_beq:  w_taken_raw = eq;
            c_op_bne:  w_taken_raw = !eq;
            c_op_blt:  w_taken_raw = lt;
            c_op_bge:  w_taken_raw = gt | eq;
            c_op_bgt:  w_taken_raw = gt;
            c_op_ble:  w_taken_raw = lt | eq;
            c_op_jump: w_taken_raw = 1'b1;
            default:   w_taken_raw = 1'b0;
        endcase
    end

    // Conditional ops trust the comparator only when exactly one flag is set.
    assign w_onehot   = (lt & !eq & !gt) | (!lt & eq & !gt) | (!lt & !eq & gt);
    assign w_flag_bad = (br_op != c_op_none) && (br_op != c_op_jump) && !w_onehot;
    assign w_taken    = w_taken_raw & !w_flag_bad;

    assign w_seq_pc   = pc + 32'd4;
    assign w_target   = w_seq_pc + (imm << 2);
    assign w_next_pc  = w_taken ? w_target : w_seq_pc;

    assign w_accept   = in_valid & r_in_ready & !flush;
    assign w_xfer     = r_out_valid & out_ready;
    assign w_out_free = !r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_out_taken    <= 1'b0;
            r_out_counted  <= 1'b0;
            r_out_target   <= 32'd0;
            r_out_next_pc  <= 32'd0;
            r_skid_valid   <= 1'b0;
            r_skid_taken   <= 1'b0;
            r_skid_counted <= 1'b0;
            r_skid_target  <= 32'd0;
            r_skid_next_pc <= 32'd0;
            r_flag_err     <= 1'b0;
            r_branch_count <= '0;
            r_taken_count  <= '0;
        end else begin
            if (w_accept && w_flag_bad) begin
                r_flag_err <= 1'b1;
            end

            if (w_xfer) begin
                if (r_out_counted && (r_branch_count != c_cnt_max)) begin
                    r_branch_count <= r_branch_count + c_cnt_one;
                end
                if (r_out_taken && (r_taken_count != c_cnt_max)) begin
                    r_taken_count <= r_taken_count + c_cnt_one;
                end
            end

            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_out_free) begin
                // Skid is never loaded while it is full, so it always drains first.
                r_in_ready   <= 1'b1;
                r_skid_valid <= 1'b0;
                if (r_skid_valid) begin
                    r_out_valid   <= 1'b1;
                    r_out_taken   <= r_skid_taken;
                    r_out_counted <= r_skid_counted;
                    r_out_target  <= r_skid_target;
                    r_out_next_pc <= r_skid_next_pc;
                end else if (w_accept) begin
                    r_out_valid   <= 1'b1;
                    r_out_taken   <= w_taken;
                    r_out_counted <= (br_op != c_op_none);
                    r_out_target  <= w_target;
                    r_out_next_pc <= w_next_pc;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else begin
                if (w_accept) begin
                    r_skid_valid   <= 1'b1;
                    r_skid_taken   <= w_taken;
                    r_skid_counted <= (br_op != c_op_none);
                    r_skid_target  <= w_target;
                    r_skid_next_pc <= w_next_pc;
                end
                r_in_ready <= !(r_skid_valid | w_accept);
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_taken    = r_out_taken;
    assign out_target   = r_out_target;
    assign out_next_pc  = r_out_next_pc;
    assign flag_err     = r_flag_err;
    assign branch_count = r_branch_count;
    assign taken_count  = r_taken_count;

endmodule
`default_nettype wire
